// File: rtl/step_pulse_generator.sv
// Step/dir pulse generator feeding the microstepper core.
// Accepts move commands over valid/ready, emits the commanded number of step
// pulses with programmable dir setup and step high time, then pulses done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high unless abort
// ST_SETUP | dir driven, counting down setup time before first step rise
// ST_HIGH  | step high, counting down high time
// ST_LOW   | step low, waiting for the period counter to expire
module step_pulse_generator #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [COUNT_WIDTH-1:0]  cmd_steps,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic [7:0]              config_dir_setup,
  input  logic [7:0]              config_step_high,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  steps_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

  logic [1:0]              state_q, state_d;
  logic [7:0]              timer_q, timer_d;      // shared setup / high down-counter
  logic [PERIOD_WIDTH-1:0] per_q, per_d;          // rise-to-rise down-counter
  logic [PERIOD_WIDTH-1:0] per_lat_q, per_lat_d;  // clamped period latched at accept
  logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
  logic [COUNT_WIDTH-1:0]  steps_done_q, steps_done_d;
  logic                    step_q, step_d;
  logic                    dir_q, dir_d;
  logic                    done_q, done_d;
  logic                    zero_pend_q, zero_pend_d;
  logic                    abort_pend_q, abort_pend_d;

  logic [7:0]              s_val;
  logic [7:0]              h_val;
  logic [8:0]              h_plus1;
  logic [PERIOD_WIDTH-1:0] h_plus1_ext;
  logic [PERIOD_WIDTH-1:0] p_val;
  logic                    accept;

  // Clamped timing values; a zero setting would otherwise stall or runt.
  always_comb begin
    s_val       = (config_dir_setup == 8'd0) ? 8'd1 : config_dir_setup;
    h_val       = (config_step_high == 8'd0) ? 8'd1 : config_step_high;
    h_plus1     = {1'b0, h_val} + 9'd1;
    h_plus1_ext = PERIOD_WIDTH'(h_plus1);
    p_val       = (cmd_period < h_plus1_ext) ? h_plus1_ext : cmd_period;
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign steps_done = steps_done_q;

  // Next-state and datapath logic for the move sequencer.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    per_d        = per_q;
    per_lat_d    = per_lat_q;
    rem_d        = rem_q;
    steps_done_d = steps_done_q;
    step_d       = step_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    zero_pend_d  = 1'b0;
    abort_pend_d = abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        // A zero-step command finishes one cycle after its accept.
        done_d = zero_pend_q;
        if (accept) begin
          steps_done_d = '0;
          rem_d        = cmd_steps;
          per_lat_d    = p_val;
          abort_pend_d = 1'b0;
          if (cmd_steps == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            dir_d   = cmd_dir;
            timer_d = s_val;
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_q <= 8'd1) begin
          state_d = ST_HIGH;
          step_d  = 1'b1;
          timer_d = h_val;
          per_d   = per_lat_q;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      ST_HIGH: begin
        // Abort is remembered so the current pulse always runs its full width.
        if (abort) abort_pend_d = 1'b1;
        if (per_q > PER_ONE) per_d = per_q - PER_ONE;
        if (timer_q <= 8'd1) begin
          step_d       = 1'b0;
          steps_done_d = steps_done_q + CNT_ONE;
          rem_d        = rem_q - CNT_ONE;
          if ((rem_q == CNT_ONE) || abort || abort_pend_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      default: begin  // ST_LOW
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (per_q <= PER_ONE) begin
          state_d = ST_HIGH;
          step_d  = 1'b1;
          timer_d = h_val;
          per_d   = per_lat_q;
        end else begin
          per_d = per_q - PER_ONE;
        end
      end
    endcase
  end

  // State and output registers; reset drops step immediately and discards the move.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      per_q        <= '0;
      per_lat_q    <= '0;
      rem_q        <= '0;
      steps_done_q <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      zero_pend_q  <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      per_q        <= per_d;
      per_lat_q    <= per_lat_d;
      rem_q        <= rem_d;
      steps_done_q <= steps_done_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      zero_pend_q  <= zero_pend_d;
      abort_pend_q <= abort_pend_d;
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Scoreboard bench for step_pulse_generator: the driver pushes hand-computed
// step edges and done events, a monitor pops and compares them as they occur.
module tb_step_pulse_generator;
  localparam int CW = 16;
  localparam int PW = 16;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_steps = '0;
  logic [PW-1:0] cmd_period = '0;
  logic [7:0]    cfg_setup = 8'd0;
  logic [7:0]    cfg_high = 8'd0;
  logic          abort = 1'b0;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_done;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  step_pulse_generator #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dir          (cmd_dir),
    .cmd_steps        (cmd_steps),
    .cmd_period       (cmd_period),
    .config_dir_setup (cfg_setup),
    .config_step_high (cfg_high),
    .abort            (abort),
    .step             (step),
    .dir              (dir),
    .busy             (busy),
    .done             (done),
    .steps_done       (steps_done)
  );

  initial forever #5 clk = ~clk;

  // Edge index: constant from a rising edge up to just before the next one.
  function automatic int now_edge();
    return int'(($time + 5) / 10);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input int k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endfunction

  task automatic expect_ev(input int kind, input int e, input int val, input string nm);
    ev_t x;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_unexpected: event at edge %0d value %0d, expected none", nm, e, val);
    end else begin
      x = q.pop_front();
      check({nm, "_kind"}, kind, x.kind);
      check({nm, "_edge"}, e, x.cyc);
      check({nm, "_val"}, val, x.val);
    end
  endtask

  // Monitor: detect step edges and done pulses, compare against the queue.
  initial begin : monitor
    logic prev_step;
    int   e;
    prev_step = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      e = now_edge();
      if (resetn && mon_en) begin
        if (step && !prev_step) expect_ev(K_RISE, e, int'(dir), "rise");
        if (!step && prev_step) expect_ev(K_FALL, e, int'(steps_done), "fall");
        if (done) begin
          expect_ev(K_DONE, e, int'(steps_done), "done");
          check("done_busy", longint'(busy), 0);
        end
      end
      prev_step = step;
    end
  end

  task automatic send(input logic d, input int n, input int per, output int t);
    int b;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = CW'(n);
    cmd_period = PW'(per);
    b = 0;
    while (!cmd_ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: cmd_ready %0d after %0d cycles, expected 1", cmd_ready, b);
      cmd_valid = 1'b0;
      t = -1000;
    end else begin
      @(posedge clk);
      t = now_edge();
    end
  endtask

  task automatic drop();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int b;
    b = 0;
    while (q.size() != 0 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d events outstanding, expected 0", nm, q.size());
      q.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int t;
    int t2;
    int b;

    // Reset values while held in reset.
    #1;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps_done", steps_done, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_release_ready", cmd_ready, 1);

    // Reset asserted mid-pulse on the second step: everything clears with no clock.
    cfg_setup = 8'd2;
    cfg_high  = 8'd5;
    send(1'b1, 3, 10, t);
    drop();
    b = 0;
    while (!(step && steps_done == CW'(1)) && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("rst_reach_pulse2", longint'(step && steps_done == CW'(1)), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_step", step, 0);
    check("rst_mid_dir", dir, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_steps_done", steps_done, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_mid_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("rst_no_restart", step, 0);
    mon_en = 1'b1;

    // Main case: setup 2, high 3, period 10, 4 steps, dir 1.
    cfg_setup = 8'd2;
    cfg_high  = 8'd3;
    send(1'b1, 4, 10, t);
    push(K_RISE, t + 2, 1);  push(K_FALL, t + 5, 1);
    push(K_RISE, t + 12, 1); push(K_FALL, t + 15, 2);
    push(K_RISE, t + 22, 1); push(K_FALL, t + 25, 3);
    push(K_RISE, t + 32, 1); push(K_FALL, t + 35, 4);
    push(K_DONE, t + 35, 4);
    drop();
    #1;
    check("main_busy", busy, 1);
    wait_drain("main");

    // Period clamp: period 2 < high+1, spacing becomes 4 with 1 low cycle.
    send(1'b1, 3, 2, t);
    push(K_RISE, t + 2, 1);  push(K_FALL, t + 5, 1);
    push(K_RISE, t + 6, 1);  push(K_FALL, t + 9, 2);
    push(K_RISE, t + 10, 1); push(K_FALL, t + 13, 3);
    push(K_DONE, t + 13, 3);
    drop();
    wait_drain("clamp");

    // Zero config values clamp to setup 1, high 1, period 2; leaves dir at 0.
    cfg_setup = 8'd0;
    cfg_high  = 8'd0;
    send(1'b0, 1, 0, t);
    push(K_RISE, t + 1, 0);
    push(K_FALL, t + 2, 1);
    push(K_DONE, t + 2, 1);
    drop();
    wait_drain("min_clamp");

    // Zero steps with dir 1 while dir is 0: done at T+1, dir unchanged.
    send(1'b1, 0, 10, t);
    push(K_DONE, t + 1, 0);
    drop();
    check("zero_busy", busy, 0);
    wait_drain("zero");
    check("zero_dir", dir, 0);
    check("zero_steps_done", steps_done, 0);

    // Abort during HIGH of pulse 2: full 5-cycle pulse, then done.
    cfg_setup = 8'd2;
    cfg_high  = 8'd5;
    send(1'b1, 5, 10, t);
    push(K_RISE, t + 2, 1);  push(K_FALL, t + 7, 1);
    push(K_RISE, t + 12, 1); push(K_FALL, t + 17, 2);
    push(K_DONE, t + 17, 2);
    drop();
    while (now_edge() < t + 13) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort_high");

    // Abort during LOW: idle at next edge, no further rise.
    send(1'b1, 5, 10, t);
    push(K_RISE, t + 2, 1);
    push(K_FALL, t + 7, 1);
    push(K_DONE, t + 9, 1);
    drop();
    while (now_edge() < t + 8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort_low");

    // Abort in IDLE only blocks cmd_ready.
    abort = 1'b1;
    #1;
    check("idle_abort_ready", cmd_ready, 0);
    abort = 1'b0;
    #1;
    check("idle_release_ready", cmd_ready, 1);

    // Back-to-back: second command held valid, accepted on first move's done cycle.
    cfg_setup = 8'd2;
    cfg_high  = 8'd3;
    send(1'b1, 2, 6, t);
    push(K_RISE, t + 2, 1); push(K_FALL, t + 5, 1);
    push(K_RISE, t + 8, 1); push(K_FALL, t + 11, 2);
    push(K_DONE, t + 11, 2);
    send(1'b0, 2, 6, t2);
    check("b2b_accept_edge", t2, t + 12);
    push(K_RISE, t2 + 2, 0); push(K_FALL, t2 + 5, 1);
    push(K_RISE, t2 + 8, 0); push(K_FALL, t2 + 11, 2);
    push(K_DONE, t2 + 11, 2);
    drop();
    wait_drain("b2b");

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/step_pulse_generator.md
# step_pulse_generator

Command-driven step/dir pulse generator that sits directly upstream of the microstepper core and drives its `step` and `dir` inputs. It accepts move commands (direction, step count, step period) over a valid/ready handshake. It emits exactly the commanded number of step pulses with programmable direction setup time and high time. Each move ends with a completion pulse and a step-count readback.

## Interface
Parameters:
- `COUNT_WIDTH`, 16, width of step count and `steps_done`.
- `PERIOD_WIDTH`, 16, width of step period in clocks; must be >= 9.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `resetn`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE with `abort` low.
- `cmd_dir`  in  1  direction for the move.
- `cmd_steps`  in  COUNT_WIDTH  number of pulses, 0..2^COUNT_WIDTH-1.
- `cmd_period`  in  PERIOD_WIDTH  clocks between consecutive step rising edges.
- `config_dir_setup`  in  8  clocks `dir` is stable before the first step rise.
- `config_step_high`  in  8  step high time in clocks.
- `abort`  in  1  terminate the current move cleanly.
- `step`  out  1  step pulse to the microstepper.
- `dir`  out  1  direction to the microstepper; registered.
- `busy`  out  1  move in progress (state != IDLE).
- `done`  out  1  one-cycle pulse when a move completes or is aborted.
- `steps_done`  out  COUNT_WIDTH  pulses completed in the current or last move.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW. All outputs are registered.
- Derived values:
  - S = max(`config_dir_setup`, 1).
  - H = max(`config_step_high`, 1).
  - P = max(`cmd_period`, H+1). The comparison is done zero-extended to PERIOD_WIDTH.
  - P is latched at accept. `config_*` are sampled at the point of use.
- IDLE: accept fires on `cmd_valid && cmd_ready` at a clock edge. On accept:
  - Latch the command and clear `steps_done`.
  - If `cmd_steps`==0: stay in IDLE, leave `dir` unchanged, pulse `done` on the next cycle.
  - Otherwise: set `dir`<=`cmd_dir` and go to SETUP with the timer loaded to S.
- SETUP: hold for S cycles, then go to HIGH. `step` rises on the transition.
- HIGH: `step`=1 for H cycles.
  - At the end of HIGH, `steps_done` increments by 1 and `step` falls.
  - If remaining==0, go to IDLE and assert `done`. Otherwise go to LOW.
- LOW: hold `step`=0 until P cycles have elapsed since the previous rise, then go to HIGH.
- Abort behaviour:
  - Abort in SETUP or LOW: go to IDLE at the next edge and pulse `done`. `step` stays 0.
  - Abort in HIGH: the pulse completes its full H cycles (no runt pulses), `steps_done` increments, then go to IDLE and pulse `done`.
  - Abort in IDLE: only blocks `cmd_ready`.
- A command presented while busy is held off by `cmd_ready`=0.
- Back-to-back moves: a command valid on the `done` cycle is accepted on that same edge, because the block is already in IDLE.
- `dir` changes only on accept, never while `step`=1.

## Timing
- Reset values (asynchronous, take effect immediately):
  - State IDLE.
  - `step`=0, `dir`=0, `busy`=0, `done`=0, `steps_done`=0.
  - `cmd_ready`=1 once `resetn` is high and `abort` is low.
- Accept at edge T with N>0 steps:
  - `busy`=1 and the new `dir` are visible from T.
  - Pulse k (k=0..N-1) rises at edge T+S+k·P and falls at T+S+k·P+H.
  - `steps_done` equals k+1 from that falling edge.
- Completion: `done`=1, `busy`=0 and `cmd_ready`=1 are all visible from edge T+S+(N-1)·P+H, for exactly one cycle of `done`.
- N=0: `done`=1 from edge T+1, for one cycle. `busy` stays 0.
- Latency from accept to first step rise is S cycles (minimum 1).
- Reset mid-move: `step` drops to 0 immediately and the latched command is discarded.
- No counter wraps during a move:
  - The remaining counter is COUNT_WIDTH wide.
  - The period counter is PERIOD_WIDTH wide.
  - The setup and high counters are 8 bits wide.

## Test plan
- Reset: assert `resetn`=0 mid-pulse -> `step`=0, `dir`=0, `busy`=0, `done`=0, `steps_done`=0 with no clock; `cmd_ready`=1 after release.
- Setup=2, high=3, period=10, steps=4, dir=1, accepted at T -> rises at T+2/12/22/32, each high 3 cycles; `done` at T+35; `steps_done`=4.
- Period clamp: high=3, period=2, steps=3 -> rise-to-rise spacing 4 cycles; `step` low exactly 1 cycle between pulses.
- Zero steps: accept with `cmd_steps`=0, dir=1 while `dir`=0 -> `done` at T+1, no step, `dir` stays 0, `steps_done`=0.
- Abort during HIGH of pulse 2 (high=5) -> pulse lasts full 5 cycles, then IDLE, `done` pulse, `steps_done`=2; abort during LOW -> IDLE next edge, no further rise.
- Back-to-back: `cmd_valid` held with a second command (steps=2, dir=0) -> accepted on the first move's `done` cycle; `dir` flips only after `step` is low; the second move's first rise comes S cycles after accept.
